// File: rtl/dmem_access_pkg.sv
// Shared CPU definitions: pipeline register word width, data-memory access FSM
// states and the default memory acknowledge timeout.
package dmem_access_pkg;

   // Width of the EX/MEM and MEM/WB data and address fields.
   localparam int unsigned Xlen = 32;

   localparam int unsigned DmemTimeoutDefault = 16;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } dmem_state_e;

endpackage

// File: rtl/dmem_access.sv
// MEM-stage data memory access: issues one registered request per load/store,
// stalls the pipeline until ack or timeout, and flags misaligned accesses.
module dmem_access
   import dmem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = DmemTimeoutDefault
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic [Xlen-1:0] addr_i,
   input  logic [Xlen-1:0] wdata_i,
   output logic            stall_o,
   output logic [Xlen-1:0] rdata_o,
   output logic            misalign_o,
   output logic            buserr_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [Xlen-1:0] mem_addr_o,
   output logic [Xlen-1:0] mem_wdata_o,
   input  logic            mem_ack_i,
   input  logic [Xlen-1:0] mem_rdata_i
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   dmem_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [Xlen-1:0] mem_addr_q, mem_addr_d;
   logic [Xlen-1:0] mem_wdata_q, mem_wdata_d;
   logic [Xlen-1:0] rdata_q, rdata_d;
   logic            buserr_q, buserr_d;

   logic access;
   logic aligned;

   assign access  = MemRead_i | MemWrite_i;
   assign aligned = (addr_i[1:0] == 2'b00);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      buserr_d    = buserr_q;
      stall_o     = 1'b0;
      misalign_o  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (access && aligned) begin
               stall_o     = 1'b1;
               state_d     = StWait;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = MemWrite_i;
               mem_addr_d  = addr_i;
               mem_wdata_d = wdata_i;
            end else if (access) begin
               misalign_o = 1'b1;
               rdata_d    = '0;
            end
         end
         StWait: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               state_d   = StDone;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  rdata_d = mem_rdata_i;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d   = StDone;
                  mem_req_d = 1'b0;
                  buserr_d  = 1'b1;
                  rdata_d   = '0;
               end
            end
         end
         StDone: begin
            state_d  = StIdle;
            buserr_d = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // The pipeline must never be held while reset is being applied.
      if (rst_i) begin
         stall_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         buserr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         buserr_q    <= buserr_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign buserr_o    = buserr_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: a cycle-by-cycle vector table plus hand-written
// store, timeout and reset-abandon sequences.
module tb_dmem_access;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        misalign_o;
   logic        buserr_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;

   dmem_access #(
      .TIMEOUT(16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .stall_o    (stall_o),
      .rdata_o    (rdata_o),
      .misalign_o (misalign_o),
      .buserr_o   (buserr_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] mrd;
      logic        e_stall;
      logic        e_mis;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic        e_berr;
   } vec_t;

   vec_t vecs[16];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic ack, input logic [31:0] mrd);
      MemRead_i   = rd;
      MemWrite_i  = wr;
      addr_i      = a;
      wdata_i     = wd;
      mem_ack_i   = ack;
      mem_rdata_i = mrd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      //                rd    wr    addr          wdata         ack   mrd
      //                stall mis   req   we    e_addr        e_wdata       e_rdata       berr
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h1111_1111,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'h2222_2222,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h1111_1111, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h2222_2222, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h2222_2222, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h2222_2222, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h2222_2222, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1'b1, 32'hFFFF_FFFF,
                   1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'hAAAA_5555, 32'h2222_2222, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hAAAA_5555, 32'h2222_2222, 1'b0};

      // Reset with an aligned load pending: stall must stay low.
      rst_i = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk1("reset_stall", stall_o, 1'b0);
      chk1("reset_req", mem_req_o, 1'b0);
      chk1("reset_we", mem_we_o, 1'b0);
      chk1("reset_buserr", buserr_o, 1'b0);
      chk32("reset_addr", mem_addr_o, 32'h0);
      chk32("reset_wdata", mem_wdata_o, 32'h0);
      chk32("reset_rdata", rdata_o, 32'h0);
      rst_i = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mrd);
         chk1($sformatf("v%0d_stall", i), stall_o, vecs[i].e_stall);
         chk1($sformatf("v%0d_misalign", i), misalign_o, vecs[i].e_mis);
         chk1($sformatf("v%0d_req", i), mem_req_o, vecs[i].e_req);
         chk1($sformatf("v%0d_we", i), mem_we_o, vecs[i].e_we);
         chk32($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].e_addr);
         chk32($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].e_wdata);
         chk32($sformatf("v%0d_rdata", i), rdata_o, vecs[i].e_rdata);
         chk1($sformatf("v%0d_buserr", i), buserr_o, vecs[i].e_berr);
         tick();
      end

      // Store 0x12345678 to 0x20, ack on the fifth WAIT cycle.
      drive(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
      chk1("st_idle_stall", stall_o, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 32'h20, 32'h1234_5678, (i == 4), 32'hBADB_AD00);
         chk1($sformatf("st_w%0d_stall", i), stall_o, 1'b1);
         chk1($sformatf("st_w%0d_req", i), mem_req_o, 1'b1);
         chk1($sformatf("st_w%0d_we", i), mem_we_o, 1'b1);
         chk32($sformatf("st_w%0d_addr", i), mem_addr_o, 32'h20);
         chk32($sformatf("st_w%0d_wdata", i), mem_wdata_o, 32'h1234_5678);
         tick();
      end
      drive(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
      chk1("st_done_stall", stall_o, 1'b0);
      chk1("st_done_req", mem_req_o, 1'b0);
      chk32("st_done_rdata", rdata_o, 32'h2222_2222);
      tick();

      // Load with no ack: 16 WAIT cycles, then DONE with bus error.
      drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);
      chk1("to_idle_stall", stall_o, 1'b1);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h5555_AAAA);
         chk1($sformatf("to_w%0d_req", i), mem_req_o, 1'b1);
         chk1($sformatf("to_w%0d_stall", i), stall_o, 1'b1);
         chk1($sformatf("to_w%0d_buserr", i), buserr_o, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h5555_AAAA);
      chk1("to_done_stall", stall_o, 1'b0);
      chk1("to_done_req", mem_req_o, 1'b0);
      chk1("to_done_buserr", buserr_o, 1'b1);
      chk32("to_done_rdata", rdata_o, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk1("to_after_buserr", buserr_o, 1'b0);
      chk32("to_after_rdata", rdata_o, 32'h0);
      tick();

      // Reset in the second WAIT cycle; a late ack must be ignored.
      drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
      chk1("rs_w1_req", mem_req_o, 1'b1);
      tick();
      rst_i = 1'b1;
      drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
      chk1("rs_w2_stall", stall_o, 1'b0);
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
         chk1($sformatf("rs_a%0d_req", i), mem_req_o, 1'b0);
         chk1($sformatf("rs_a%0d_stall", i), stall_o, 1'b0);
         chk1($sformatf("rs_a%0d_buserr", i), buserr_o, 1'b0);
         chk32($sformatf("rs_a%0d_rdata", i), rdata_o, 32'h0);
         chk32($sformatf("rs_a%0d_addr", i), mem_addr_o, 32'h0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
      chk1("rs_new_stall", stall_o, 1'b1);
      tick();
      drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 32'h0BAD_F00D);
      chk1("rs_new_req", mem_req_o, 1'b1);
      chk32("rs_new_addr", mem_addr_o, 32'h60);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk1("rs_new_done_stall", stall_o, 1'b0);
      chk32("rs_new_rdata", rdata_o, 32'h0BAD_F00D);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
